// File: rtl/tmds_channel_sequencer.sv
// One TMDS colour channel for an HDMI/DVI transmitter. Pixels are delayed LEAD cycles
// so that the video preamble and guard band can be emitted in front of active video.
module tmds_channel_sequencer #(
    parameter int CHANNEL  = 0,
    parameter bit GUARD_EN = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [7:0] data_in,
    input  logic [1:0] control_in,
    input  logic       ve_in,
    output logic [9:0] tmds_out,
    output logic       err_out
);

    localparam int LEAD    = 10;
    localparam int PRE_LEN = 8;

    localparam logic [1:0] ST_CTRL     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_GUARD    = 2'd2;
    localparam logic [1:0] ST_VIDEO    = 2'd3;

    localparam logic [9:0] GUARD_WORD = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

    typedef struct packed {
        logic       ve;
        logic [1:0] ctrl;
        logic [7:0] data;
    } stage_t;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Transition-minimisation stage: q[8]=1 marks the XOR chain, q[8]=0 the XNOR chain.
    function automatic logic [8:0] tm_choice(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1 = '0;
        for (int i = 0; i < 8; i++) n1 = n1 + 4'(d[i]);
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    stage_t            r_dl [LEAD];
    logic [1:0]        r_state;
    logic [3:0]        r_phase;
    logic signed [4:0] r_cnt;

    stage_t            w_d;
    logic              w_any_ve;
    logic              w_rise;
    logic              w_start;
    logic              w_short;
    logic [1:0]        w_state;
    logic [3:0]        w_phase;
    logic [1:0]        w_pre_ctrl;
    logic [8:0]        w_qm;
    logic [3:0]        w_n1;
    logic signed [4:0] w_diff;
    logic signed [4:0] w_cnt_next;
    logic [9:0]        w_video;

    assign w_d        = r_dl[LEAD-1];
    assign w_rise     = ve_in && !r_dl[0].ve;
    assign w_start    = GUARD_EN && w_rise && !w_any_ve
                        && (r_state == ST_CTRL || r_state == ST_VIDEO);
    assign w_short    = GUARD_EN && w_rise && w_any_ve;
    assign w_pre_ctrl = (CHANNEL == 0) ? w_d.ctrl : ((CHANNEL == 1) ? 2'b01 : 2'b00);
    assign w_qm       = tm_choice(w_d.data);

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        w_any_ve = 1'b0;
        for (int i = 0; i < LEAD; i++) w_any_ve = w_any_ve | r_dl[i].ve;
    end

    // The next state is also the mode of the symbol registered at this edge, so the
    // first preamble symbol appears the cycle after ve_in rises.
    always_comb begin
        w_state = ST_CTRL;
        w_phase = '0;
        case (r_state)
            ST_PREAMBLE: begin
                if (r_phase == 4'(PRE_LEN - 1)) begin
                    w_state = ST_GUARD;
                end else begin
                    w_state = ST_PREAMBLE;
                    w_phase = r_phase + 4'd1;
                end
            end
            ST_GUARD: begin
                if (r_phase == 4'd0) begin
                    w_state = ST_GUARD;
                    w_phase = 4'd1;
                end else begin
                    w_state = w_d.ve ? ST_VIDEO : ST_CTRL;
                end
            end
            default: begin
                if (w_start) w_state = ST_PREAMBLE;
                else         w_state = w_d.ve ? ST_VIDEO : ST_CTRL;
            end
        endcase
    end

    // DC balancing; w_diff is n1 - n0 of q_m[7:0], always within -8..+8.
    always_comb begin
        w_n1 = '0;
        for (int i = 0; i < 8; i++) w_n1 = w_n1 + 4'(w_qm[i]);
        w_diff     = $signed({w_n1, 1'b0}) - 5'sd8;
        w_video    = '0;
        w_cnt_next = r_cnt;
        if (r_cnt == 5'sd0 || w_n1 == 4'd4) begin
            w_video    = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
            w_cnt_next = w_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if ((r_cnt > 5'sd0 && w_n1 > 4'd4) || (r_cnt < 5'sd0 && w_n1 < 4'd4)) begin
            w_video    = {1'b1, w_qm[8], ~w_qm[7:0]};
            w_cnt_next = r_cnt - w_diff + (w_qm[8] ? 5'sd2 : 5'sd0);
        end else begin
            w_video    = {1'b0, w_qm[8], w_qm[7:0]};
            w_cnt_next = r_cnt + w_diff - (w_qm[8] ? 5'sd0 : 5'sd2);
        end
    end

    // NOTE: the delay line is reset stage by stage so a fresh line never looks like video.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < LEAD; i++) r_dl[i] <= '0;
        end else begin
            r_dl[0] <= {ve_in, control_in, data_in};
            for (int i = 1; i < LEAD; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tmds_out <= 10'b1101010100;
            err_out  <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_CTRL;
            r_phase  <= '0;
        end else begin
            r_state <= w_state;
            r_phase <= w_phase;
            err_out <= w_short;
            case (w_state)
                ST_PREAMBLE: begin
                    tmds_out <= ctrl_token(w_pre_ctrl);
                    r_cnt    <= '0;
                end
                ST_GUARD: begin
                    tmds_out <= GUARD_WORD;
                    r_cnt    <= '0;
                end
                ST_VIDEO: begin
                    tmds_out <= w_video;
                    r_cnt    <= w_cnt_next;
                end
                default: begin
                    tmds_out <= ctrl_token(w_d.ctrl);
                    r_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_channel_sequencer.sv
// Bench for tmds_channel_sequencer: four parameterisations share one stimulus stream and
// are scored every cycle against an input-history model, plus directed vector tables.
module tb_tmds_channel_sequencer;

    localparam int         NI    = 4;
    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK10 = 10'b0101010100;

    typedef struct packed {
        logic       ve;
        logic [1:0] ctrl;
        logic [7:0] data;
    } smp_t;

    typedef struct {
        logic       ve;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic [9:0] exp_tmds;
        logic       exp_err;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data  = '0;
    logic [1:0] ctrl  = '0;
    logic       ve    = 1'b0;
    logic [9:0] tmds_o [NI];
    logic       err_o  [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tmds_channel_sequencer #(.CHANNEL(0), .GUARD_EN(1'b0)) u_dvi0 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .control_in(ctrl), .ve_in(ve),
        .tmds_out(tmds_o[0]), .err_out(err_o[0]));
    tmds_channel_sequencer #(.CHANNEL(0), .GUARD_EN(1'b1)) u_hdmi0 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .control_in(ctrl), .ve_in(ve),
        .tmds_out(tmds_o[1]), .err_out(err_o[1]));
    tmds_channel_sequencer #(.CHANNEL(1), .GUARD_EN(1'b1)) u_hdmi1 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .control_in(ctrl), .ve_in(ve),
        .tmds_out(tmds_o[2]), .err_out(err_o[2]));
    tmds_channel_sequencer #(.CHANNEL(2), .GUARD_EN(1'b1)) u_hdmi2 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .control_in(ctrl), .ve_in(ve),
        .tmds_out(tmds_o[3]), .err_out(err_o[3]));

    // Reference model: hist[k] is the sample taken k edges ago; m_ovr counts symbols
    // already replaced by an inserted preamble/guard run (-1 when none is running).
    int         ch_of [NI] = '{0, 0, 1, 2};
    bit         ge_of [NI] = '{1'b0, 1'b1, 1'b1, 1'b1};
    smp_t       hist  [11];
    int         m_cnt [NI];
    int         m_ovr [NI];
    logic [9:0] m_tmds [NI];
    logic       m_err  [NI];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] model_video(input int i, input logic [7:0] d);
        int         ones_d, n1, n0;
        bit         use_xnor, q8;
        logic [7:0] q;
        logic [9:0] sym;
        ones_d   = $countones(d);
        use_xnor = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
        q[0]     = d[0];
        for (int b = 1; b < 8; b++) q[b] = use_xnor ? ~(q[b-1] ^ d[b]) : (q[b-1] ^ d[b]);
        q8 = !use_xnor;
        n1 = $countones(q);
        n0 = 8 - n1;
        if (m_cnt[i] == 0 || n1 == n0) begin
            sym      = {~q8, q8, q8 ? q : ~q};
            m_cnt[i] = m_cnt[i] + (q8 ? (n1 - n0) : (n0 - n1));
        end else if ((m_cnt[i] > 0 && n1 > n0) || (m_cnt[i] < 0 && n0 > n1)) begin
            sym      = {1'b1, q8, ~q};
            m_cnt[i] = m_cnt[i] + (q8 ? 2 : 0) + (n0 - n1);
        end else begin
            sym      = {1'b0, q8, q};
            m_cnt[i] = m_cnt[i] + (n1 - n0) - (q8 ? 0 : 2);
        end
        return sym;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 11; k++) hist[k] = '0;
        for (int i = 0; i < NI; i++) begin
            m_cnt[i]  = 0;
            m_ovr[i]  = -1;
            m_tmds[i] = TOK00;
            m_err[i]  = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        bit   rise, clear;
        smp_t old;
        for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = {ve, ctrl, data};
        old     = hist[10];
        rise    = hist[0].ve && !hist[1].ve;
        clear   = 1'b1;
        for (int k = 1; k <= 10; k++) if (hist[k].ve) clear = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_err[i] = ge_of[i] && rise && !clear;
            if (ge_of[i] && rise && clear && m_ovr[i] < 0) m_ovr[i] = 0;
            if (m_ovr[i] >= 0 && m_ovr[i] < 8) begin
                m_tmds[i] = tok(ch_of[i] == 0 ? old.ctrl : (ch_of[i] == 1 ? 2'b01 : 2'b00));
                m_cnt[i]  = 0;
            end else if (m_ovr[i] >= 8) begin
                m_tmds[i] = (ch_of[i] == 1) ? 10'b0100110011 : 10'b1011001100;
                m_cnt[i]  = 0;
            end else if (old.ve) begin
                m_tmds[i] = model_video(i, old.data);
            end else begin
                m_tmds[i] = tok(old.ctrl);
                m_cnt[i]  = 0;
            end
            if (m_ovr[i] >= 0) m_ovr[i] = (m_ovr[i] == 9) ? -1 : m_ovr[i] + 1;
        end
    endfunction

    task automatic compare_all();
        logic [4:0] c [NI];
        c[0] = u_dvi0.r_cnt;
        c[1] = u_hdmi0.r_cnt;
        c[2] = u_hdmi1.r_cnt;
        c[3] = u_hdmi2.r_cnt;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("tmds[%0d]", i), 32'(tmds_o[i]), 32'(m_tmds[i]));
            check($sformatf("err[%0d]", i), 32'(err_o[i]), 32'(m_err[i]));
            check($sformatf("cnt[%0d]", i), {{27{c[i][4]}}, c[i]}, m_cnt[i]);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then the caller drives new inputs.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else        model_edge();
        compare_all();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ve    = 1'b0;
        ctrl  = 2'b00;
        data  = 8'h00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    vec_t vecs [34];
    int   run_left;
    int   err_count;
    int   err_pos;

    initial begin
        for (int k = 0; k < 34; k++) begin
            vecs[k].ve       = (k >= 20);
            vecs[k].ctrl     = 2'b00;
            vecs[k].data     = (k >= 20) ? 8'h10 : 8'h00;
            vecs[k].exp_err  = 1'b0;
            if (k < 20)      vecs[k].exp_tmds = TOK00;
            else if (k < 28) vecs[k].exp_tmds = 10'b0010101011;
            else if (k < 30) vecs[k].exp_tmds = 10'b0100110011;
            else             vecs[k].exp_tmds = 10'b0111110000;
        end

        #1 rst_n = 1'b0;
        ctrl = 2'b10;
        step();
        check("rst_hold_tmds", 32'(tmds_o[2]), 32'(TOK00));
        check("rst_hold_err", 32'(err_o[2]), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("release_tmds", 32'(tmds_o[1]), 32'(k <= 10 ? TOK00 : TOK10));
        end

        // Channel 1 HDMI: preamble 01, guard, then the first 0x10 pixel.
        apply_reset();
        for (int k = 0; k < 34; k++) begin
            ve   = vecs[k].ve;
            ctrl = vecs[k].ctrl;
            data = vecs[k].data;
            step();
            check("vec_tmds", 32'(tmds_o[2]), 32'(vecs[k].exp_tmds));
            check("vec_err", 32'(err_o[2]), 32'(vecs[k].exp_err));
        end

        // DVI channel 0 with constant 0x00 video.
        apply_reset();
        ve   = 1'b1;
        data = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k <= 10)      check("dvi_lead", 32'(tmds_o[0]), 32'(TOK00));
            else if (k == 11) check("dvi_first", 32'(tmds_o[0]), 32'(10'b0100000000));
            else              check("dvi_second", 32'(tmds_o[0]), 32'(10'b1111111111));
        end

        // Two lines separated by a 5-cycle gap: one err pulse, no insertion on line two.
        apply_reset();
        err_count = 0;
        err_pos   = -1;
        for (int j = 0; j < 62; j++) begin
            ve   = (j >= 12 && j < 27) || (j >= 32 && j < 47);
            data = 8'($urandom);
            ctrl = 2'($urandom);
            step();
            if (err_o[3]) begin
                err_count++;
                err_pos = j;
            end
        end
        check("short_err_count", 32'(err_count), 32'd1);
        check("short_err_pos", 32'(err_pos), 32'd32);

        // Randomised lines with long and short blanking, scored against the model.
        apply_reset();
        run_left = 0;
        for (int n = 0; n < 10000; n++) begin
            if (run_left == 0) begin
                ve = ~ve;
                if (ve)                          run_left = int'($urandom_range(40, 1));
                else if ($urandom_range(3) == 0) run_left = int'($urandom_range(9, 1));
                else                             run_left = int'($urandom_range(30, 10));
            end
            run_left--;
            data = 8'($urandom);
            ctrl = 2'($urandom);
            step();
        end

        // Asynchronous reset in the middle of a preamble.
        apply_reset();
        for (int k = 0; k < 12; k++) step();
        ve = 1'b1;
        for (int k = 0; k < 4; k++) step();
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async_tmds[%0d]", i), 32'(tmds_o[i]), 32'(TOK00));
            check($sformatf("async_err[%0d]", i), 32'(err_o[i]), 32'd0);
        end
        model_reset();
        step();
        rst_n = 1'b1;
        ve    = 1'b0;
        ctrl  = 2'b00;
        for (int k = 0; k < 25; k++) begin
            step();
            check("post_reset_tmds", 32'(tmds_o[2]), 32'(TOK00));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
